vmem_port_ctrl: RTL and testbench
=================================

# vmem_port_ctrl

Memory-port controller for the CVP14 vector core. It owns the single 16-bit memory bus (Addr/RD/WR/dataOut/DataIn) and shares it between two requesters: single-word instruction fetch and multi-element vector load/store bursts. Vector bursts of up to 16 elements are sequenced with lane packing and unpacking to and from 256-bit vectors. The block sits between the core's control FSM and external memory, so the core FSM no longer drives bus signals directly.

## Interface
- ELEM_W, 16, element and memory word width
- NELEM, 16, max elements per vector; vector width = ELEM_W*NELEM
- ADDR_W, 16, memory address width
- Clk1  in  1  sole clock, all logic on rising edge
- Reset  in  1  synchronous, active-low reset (0 = reset)
- f_req  in  1  fetch request, held until f_gnt
- f_addr  in  ADDR_W  fetch address
- f_gnt  out  1  1-cycle pulse, fetch accepted and RD issued this cycle
- f_data  out  ELEM_W  fetched word, valid with f_valid
- f_valid  out  1  1-cycle pulse
- v_req  in  1  vector request, held until v_gnt
- v_wr  in  1  1 = store (VST), 0 = load (VLD)
- v_base  in  ADDR_W  first element address
- v_count  in  log2(NELEM)  index of last element; transfers v_count+1 elements
- v_wdata  in  ELEM_W*NELEM  store data; lane k = bits [16k+15:16k]
- v_gnt  out  1  1-cycle pulse, burst accepted
- v_rdata  out  ELEM_W*NELEM  load result, valid with v_done
- v_done  out  1  1-cycle pulse, burst complete
- busy  out  1  1 when not IDLE
- Addr  out  ADDR_W  memory address
- RD  out  1  memory read strobe
- WR  out  1  memory write strobe
- dataOut  out  ELEM_W  memory write data
- DataIn  in  ELEM_W  memory read data, valid the cycle after RD

## Operation
- States: IDLE, FETCH, FCAP, VLOAD, VLTAIL, VSTORE, DONE.
- IDLE: sample requests and arbitrate. The winner's address, count, direction and v_wdata are latched. Later changes to inputs are ignored until the next grant.
- FETCH (1 cycle): RD=1, Addr=latched f_addr, f_gnt=1 → FCAP.
- FCAP: capture DataIn into f_data; f_valid=1 next cycle in DONE.
- VLOAD: k = 0..count. Each cycle drives RD=1 and Addr=base+k. DataIn for element k-1 is written to lane k-1. v_gnt=1 when k=0. After k=count → VLTAIL.
- VLTAIL: capture the last element into lane count → DONE.
- VSTORE: k = 0..count. Each cycle drives WR=1, Addr=base+k, dataOut=lane k of the latched v_wdata. v_gnt=1 when k=0. After k=count → DONE.
- DONE (1 cycle): f_valid or v_done pulse → IDLE.
- Load lanes above count are 0. v_rdata holds its value until the next load's v_done.
- Addr arithmetic is mod 2^ADDR_W: base 0xFFFF plus 1 wraps to 0x0000 with no flag.
- RD and WR are never both 1. When neither strobe is active, Addr=0 and dataOut=0.
- A requester may drop its request before its grant with no effect. A request raised during a burst waits; no preemption.
- Default arbitration when both requests are high in IDLE: vector wins.

## Timing
- Reset low at an edge: every output goes to 0 (including v_rdata and f_data), state → IDLE, the latched round-robin pointer → fetch-favoured. This holds mid-burst: the burst is aborted, no done pulse is issued, and no further strobes occur.
- Fetch: request seen in IDLE at cycle T. RD/f_gnt at T+1, DataIn sampled at T+2, f_valid/f_data at T+3, IDLE at T+4. Fetch-to-fetch throughput is 1 per 4 cycles.
- Load of N = count+1 elements: RD at T+1..T+N, v_done at T+N+2.
- Store of N elements: WR at T+1..T+N, v_done at T+N+1.
- A request asserted in the same cycle the FSM enters IDLE is sampled in that cycle.

## Configuration
- VMEM_PORT_RR_EN defined: two-way round-robin arbitration. After a grant to one requester, the other wins the next simultaneous request. The pointer is reset to favour fetch.
- Not defined: fixed priority, vector over fetch. Fetch can starve under continuous v_req. This is the required default.

## Test plan
- Reset low for 2 cycles mid-VLOAD (count=15, base=0x0100) → RD/WR/Addr 0 next cycle, no v_done, busy=0, all outputs 0.
- Fetch f_addr=0x0040, memory[0x40]=0xBEEF → RD at T+1 with Addr=0x0040, f_valid and f_data=0xBEEF at T+3.
- Load base=0xFFFE, count=3, mem[0xFFFE,0xFFFF,0,1]=1,2,3,4 → Addrs 0xFFFE,0xFFFF,0x0000,0x0001; v_rdata lanes 0..3 = 1..4, lanes 4..15 = 0; v_done at T+6.
- Store count=15, v_wdata lane k = 0x1000+k, base=0x0200 → WR on 16 consecutive cycles, dataOut=0x1000+k at Addr 0x0200+k, v_done at T+17.
- f_req and v_req both held high for 3 transactions → default: vector, vector, vector. With VMEM_PORT_RR_EN: fetch, vector, fetch.
- v_base and v_count changed in the cycle after v_gnt → the transfer uses the originally latched values.

Source files
------------

// File: rtl/vmem_port_ctrl.sv
// vmem_port_ctrl: shares the 16-bit memory bus between instruction fetch and vector bursts; fetch 4 cycles, load N+2, store N+1.
// Requests are held until granted, with no preemption; define VMEM_PORT_RR_EN for round-robin arbitration (default: vector priority).
module vmem_port_ctrl #(
  parameter int ELEM_W = 16,
  parameter int NELEM  = 16,
  parameter int ADDR_W = 16
) (
  input  logic                       Clk1,
  input  logic                       Reset,
  input  logic                       f_req,
  input  logic [ADDR_W-1:0]          f_addr,
  output logic                       f_gnt,
  output logic [ELEM_W-1:0]          f_data,
  output logic                       f_valid,
  input  logic                       v_req,
  input  logic                       v_wr,
  input  logic [ADDR_W-1:0]          v_base,
  input  logic [$clog2(NELEM)-1:0]   v_count,
  input  logic [ELEM_W*NELEM-1:0]    v_wdata,
  output logic                       v_gnt,
  output logic [ELEM_W*NELEM-1:0]    v_rdata,
  output logic                       v_done,
  output logic                       busy,
  output logic [ADDR_W-1:0]          Addr,
  output logic                       RD,
  output logic                       WR,
  output logic [ELEM_W-1:0]          dataOut,
  input  logic [ELEM_W-1:0]          DataIn
);

  localparam int CW = $clog2(NELEM);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_FCAP   = 3'd2;
  localparam logic [2:0] S_VLOAD  = 3'd3;
  localparam logic [2:0] S_VLTAIL = 3'd4;
  localparam logic [2:0] S_VSTORE = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0]                          state_q, state_d;
  logic [ADDR_W-1:0]                   addr_q, addr_d;
  logic [CW-1:0]                       cnt_q, cnt_d;
  logic [CW-1:0]                       k_q, k_d;
  logic                                vec_q, vec_d;
  logic [NELEM-1:0][ELEM_W-1:0]        wdata_q, wdata_d;
  logic [NELEM-1:0][ELEM_W-1:0]        buf_q, buf_d;
  logic [NELEM-1:0][ELEM_W-1:0]        rdata_q, rdata_d;
  logic [ELEM_W-1:0]                   fdata_q, fdata_d;
  logic [CW-1:0]                       prev_k;
  logic                                pick_vec;

`ifdef VMEM_PORT_RR_EN
  // rr_q = 1 favours vector; flips to the other requester after each grant
  logic rr_q, rr_d;
  assign pick_vec = v_req && (!f_req || rr_q);
`else
  assign pick_vec = v_req;
`endif

  assign prev_k = k_q - CW'(1);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    vec_d   = vec_q;
    wdata_d = wdata_q;
    buf_d   = buf_q;
    rdata_d = rdata_q;
    fdata_d = fdata_q;
`ifdef VMEM_PORT_RR_EN
    rr_d    = rr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (pick_vec) begin
          addr_d  = v_base;
          cnt_d   = v_count;
          wdata_d = v_wdata;
          k_d     = '0;
          vec_d   = 1'b1;
          if (!v_wr) buf_d = '0;
          state_d = v_wr ? S_VSTORE : S_VLOAD;
`ifdef VMEM_PORT_RR_EN
          rr_d    = 1'b0;
`endif
        end else if (f_req) begin
          addr_d  = f_addr;
          vec_d   = 1'b0;
          state_d = S_FETCH;
`ifdef VMEM_PORT_RR_EN
          rr_d    = 1'b1;
`endif
        end
      end
      S_FETCH: state_d = S_FCAP;
      S_FCAP: begin
        fdata_d = DataIn;
        state_d = S_DONE;
      end
      S_VLOAD: begin
        // read data lags the strobe by one cycle
        if (k_q != '0) buf_d[prev_k] = DataIn;
        if (k_q == cnt_q) state_d = S_VLTAIL;
        else k_d = k_q + CW'(1);
      end
      S_VLTAIL: begin
        rdata_d        = buf_q;
        rdata_d[cnt_q] = DataIn;
        state_d        = S_DONE;
      end
      S_VSTORE: begin
        if (k_q == cnt_q) state_d = S_DONE;
        else k_d = k_q + CW'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk1) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      k_q     <= '0;
      vec_q   <= 1'b0;
      wdata_q <= '0;
      buf_q   <= '0;
      rdata_q <= '0;
      fdata_q <= '0;
`ifdef VMEM_PORT_RR_EN
      rr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      vec_q   <= vec_d;
      wdata_q <= wdata_d;
      buf_q   <= buf_d;
      rdata_q <= rdata_d;
      fdata_q <= fdata_d;
`ifdef VMEM_PORT_RR_EN
      rr_q    <= rr_d;
`endif
    end
  end

  always_comb begin
    RD      = (state_q == S_FETCH) || (state_q == S_VLOAD);
    WR      = (state_q == S_VSTORE);
    Addr    = '0;
    dataOut = '0;
    if (state_q == S_FETCH) Addr = addr_q;
    else if ((state_q == S_VLOAD) || (state_q == S_VSTORE)) Addr = addr_q + ADDR_W'(k_q);
    if (state_q == S_VSTORE) dataOut = wdata_q[k_q];
  end

  assign f_gnt   = (state_q == S_FETCH);
  assign v_gnt   = ((state_q == S_VLOAD) || (state_q == S_VSTORE)) && (k_q == '0);
  assign f_valid = (state_q == S_DONE) && !vec_q;
  assign v_done  = (state_q == S_DONE) && vec_q;
  assign busy    = (state_q != S_IDLE);
  assign f_data  = fdata_q;
  assign v_rdata = rdata_q;

endmodule

// File: tb/tb_vmem_port_ctrl.sv
// Bench for vmem_port_ctrl: table of transactions checked through a bus/result scoreboard, plus reset and arbitration sequences.
module tb_vmem_port_ctrl;

  logic         Clk1 = 1'b0;
  logic         Reset;
  logic         f_req, f_gnt, f_valid;
  logic [15:0]  f_addr, f_data;
  logic         v_req, v_wr, v_gnt, v_done, busy;
  logic [15:0]  v_base;
  logic [3:0]   v_count;
  logic [255:0] v_wdata, v_rdata;
  logic [15:0]  Addr, dataOut, DataIn;
  logic         RD, WR;

  vmem_port_ctrl dut (
    .Clk1(Clk1), .Reset(Reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_data(f_data), .f_valid(f_valid),
    .v_req(v_req), .v_wr(v_wr), .v_base(v_base), .v_count(v_count), .v_wdata(v_wdata),
    .v_gnt(v_gnt), .v_rdata(v_rdata), .v_done(v_done), .busy(busy),
    .Addr(Addr), .RD(RD), .WR(WR), .dataOut(dataOut), .DataIn(DataIn)
  );

  always #5 Clk1 = ~Clk1;

  typedef struct { int cyc; bit wr; logic [15:0] addr; logic [15:0] dat; } bus_t;
  typedef struct { int cyc; bit vec; logic [255:0] dat; } res_t;
  typedef struct { int kind; logic [15:0] addr; logic [3:0] cnt; logic [15:0] wb; int lat; logic [15:0] fexp; } vec_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit sb_en = 1'b0;
  logic [15:0] mem [65536];
  logic [15:0] ref_mem [65536];
  logic [15:0] rd_pend = 16'h0;
  logic [255:0] last_rd = '0;
  bus_t bus_q[$];
  res_t res_q[$];
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s timeout at cycle %0d", nm, cyc);
  endtask

  always @(posedge Clk1) cyc++;

  // Memory model plus bus/result monitor, all on the falling edge
  always @(negedge Clk1) begin
    bus_t b;
    res_t r;
    DataIn = rd_pend;
    rd_pend = RD ? mem[Addr] : 16'($urandom);
    if (WR) mem[Addr] = dataOut;
    if (Reset) begin
      chk("rd_wr_excl", 256'(RD & WR), 256'(0));
      if (!RD && !WR) chk("idle_bus", 256'({Addr, dataOut}), 256'(0));
      if (sb_en && (RD || WR)) begin
        if (bus_q.size() == 0) chk("bus_unexpected", 256'({RD, WR, Addr}), 256'(0));
        else begin
          b = bus_q.pop_front();
          chk("bus_cyc", 256'(cyc), 256'(b.cyc));
          chk("bus_dir", 256'(WR), 256'(b.wr));
          chk("bus_addr", 256'(Addr), 256'(b.addr));
          if (b.wr) chk("bus_wdata", 256'(dataOut), 256'(b.dat));
        end
      end
      if (sb_en && (f_valid || v_done)) begin
        if (res_q.size() == 0) chk("done_unexpected", 256'({f_valid, v_done}), 256'(0));
        else begin
          r = res_q.pop_front();
          chk("done_cyc", 256'(cyc), 256'(r.cyc));
          chk("done_kind", 256'({f_valid, v_done}), 256'({!r.vec, r.vec}));
          if (r.vec) chk("v_rdata", v_rdata, r.dat);
          else chk("f_data", 256'(f_data), r.dat);
        end
      end
    end
  end

  task automatic wait_idle(input string nm);
    int w = 0;
    while (busy && w < 100) begin @(negedge Clk1); w++; end
    if (busy) timeout(nm);
  endtask

  task automatic run_txn(input vec_t e);
    int t, n, w;
    bus_t b;
    res_t r;
    logic [255:0] wd, ed;
    wait_idle("txn_idle");
    t = cyc;
    n = (e.kind == 0) ? 1 : int'(e.cnt) + 1;
    wd = '0;
    ed = '0;
    for (int k = 0; k < n; k++) begin
      b.cyc  = t + 1 + k;
      b.wr   = (e.kind == 2);
      b.addr = e.addr + 16'(k);
      b.dat  = e.wb + 16'(k);
      if (e.kind == 2) begin
        wd[16*k +: 16] = b.dat;
        ref_mem[b.addr] = b.dat;
      end
      if (e.kind == 1) ed[16*k +: 16] = ref_mem[b.addr];
      bus_q.push_back(b);
    end
    r.cyc = t + e.lat;
    r.vec = (e.kind != 0);
    r.dat = (e.kind == 0) ? 256'(e.fexp) : (e.kind == 1) ? ed : last_rd;
    if (e.kind == 1) last_rd = ed;
    res_q.push_back(r);
    if (e.kind == 0) begin
      f_req = 1'b1; f_addr = e.addr;
    end else begin
      v_req = 1'b1; v_wr = (e.kind == 2); v_base = e.addr; v_count = e.cnt; v_wdata = wd;
    end
    w = 0;
    while (!(f_gnt || v_gnt) && w < 50) begin @(negedge Clk1); w++; end
    if (f_gnt || v_gnt) begin
      chk("gnt_cyc", 256'(cyc), 256'(t + 1));
      chk("gnt_kind", 256'({f_gnt, v_gnt}), 256'({e.kind == 0, e.kind != 0}));
    end else timeout("gnt");
    // Scramble request inputs right after the grant; the latched copy must be used
    f_req = 1'b0; v_req = 1'b0;
    f_addr = ~e.addr; v_base = ~e.addr; v_count = ~e.cnt; v_wr = ~v_wr;
    v_wdata = {8{$urandom()}};
    w = 0;
    while (res_q.size() != 0 && w < 100) begin @(negedge Clk1); w++; end
    if (res_q.size() != 0) timeout("done");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int w, g, strobes, dones;
    logic [2:0] got, exp_arb;
    // kind: 0 fetch, 1 load, 2 store
    tbl[0] = '{0, 16'h0040, 4'd0,  16'h0000, 3,  16'hBEEF};
    tbl[1] = '{1, 16'hFFFE, 4'd3,  16'h0000, 6,  16'h0000};
    tbl[2] = '{2, 16'h0200, 4'd15, 16'h1000, 17, 16'h0000};
    tbl[3] = '{1, 16'h0200, 4'd15, 16'h0000, 18, 16'h0000};
    tbl[4] = '{1, 16'h0300, 4'd0,  16'h0000, 3,  16'h0000};
    tbl[5] = '{2, 16'hFFFF, 4'd1,  16'hA500, 3,  16'h0000};
    tbl[6] = '{0, 16'h0000, 4'd0,  16'h0000, 3,  16'hA501};
    tbl[7] = '{1, 16'hFFFF, 4'd1,  16'h0000, 4,  16'h0000};
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'h3C3C;
    mem[16'h0040] = 16'hBEEF;
    mem[16'hFFFE] = 16'd1; mem[16'hFFFF] = 16'd2; mem[16'h0000] = 16'd3; mem[16'h0001] = 16'd4;
    mem[16'h0300] = 16'h5A5A;
    for (int i = 0; i < 65536; i++) ref_mem[i] = mem[i];

    Reset = 1'b0; f_req = 1'b0; v_req = 1'b0; v_wr = 1'b0;
    f_addr = '0; v_base = '0; v_count = '0; v_wdata = '0;
    repeat (3) @(negedge Clk1);
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_strobes", 256'({RD, WR, f_gnt, v_gnt, f_valid, v_done}), 256'(0));
    chk("rst_v_rdata", v_rdata, 256'(0));
    chk("rst_f_data", 256'(f_data), 256'(0));
    Reset = 1'b1;
    sb_en = 1'b1;
    @(negedge Clk1);

    for (int i = 0; i < 8; i++) run_txn(tbl[i]);
    wait_idle("tbl_end");
    sb_en = 1'b0;

    // Reset in the middle of a 16-element load
    v_req = 1'b1; v_wr = 1'b0; v_base = 16'h0100; v_count = 4'd15;
    w = 0;
    while (!v_gnt && w < 20) begin @(negedge Clk1); w++; end
    if (!v_gnt) timeout("rst_gnt");
    v_req = 1'b0;
    repeat (4) @(negedge Clk1);
    Reset = 1'b0;
    @(negedge Clk1);
    chk("midrst_bus", 256'({RD, WR, Addr, dataOut}), 256'(0));
    chk("midrst_busy", 256'(busy), 256'(0));
    chk("midrst_pulses", 256'({f_gnt, v_gnt, f_valid, v_done}), 256'(0));
    chk("midrst_v_rdata", v_rdata, 256'(0));
    chk("midrst_f_data", 256'(f_data), 256'(0));
    @(negedge Clk1);
    Reset = 1'b1;
    strobes = 0; dones = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge Clk1);
      if (RD || WR) strobes++;
      if (v_done || f_valid) dones++;
    end
    chk("postrst_strobes", 256'(strobes), 256'(0));
    chk("postrst_done", 256'(dones), 256'(0));

    // Both requesters held for three grants
    f_req = 1'b1; f_addr = 16'h0040;
    v_req = 1'b1; v_wr = 1'b0; v_base = 16'h0300; v_count = 4'd0;
    got = '0; g = 0; w = 0;
    while (g < 3 && w < 200) begin
      @(negedge Clk1);
      w++;
      if (f_gnt || v_gnt) begin
        got[g] = v_gnt;
        g++;
      end
    end
    f_req = 1'b0; v_req = 1'b0;
    if (g < 3) timeout("arb");
`ifdef VMEM_PORT_RR_EN
    exp_arb = 3'b010;
`else
    exp_arb = 3'b111;
`endif
    chk("arb_order", 256'(got), 256'(exp_arb));
    wait_idle("arb_end");

    chk("bus_q_drained", 256'(bus_q.size()), 256'(0));
    chk("res_q_drained", 256'(res_q.size()), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
